// File: rtl/axi_mem_responder_if.sv
// AXI4 bundle between a memory requester and axi_mem_responder.
// The master modport is the request-receiving (responder) side; slave is the requester.
interface axi_bus_t #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
);
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [511:0]      wdata;
    logic [63:0]       wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [511:0]      rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        input  awid, awaddr, awlen, awsize, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport slave (
        output awid, awaddr, awlen, awsize, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: one INCR burst at a time from a 512-bit-word array, byte-strobed writes.
// Define AXI_MEM_RESPONDER_STALL_EN to gate awready/arready/wready with an LFSR for random backpressure.
module axi_mem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int ID_W       = 4
) (
    input  logic     clk,
    input  logic     rstn,
    axi_bus_t.master axi
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] idx_t;
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_t;
    typedef enum logic {PRIO_READ, PRIO_WRITE} prio_t;

    state_t          r_state;
    prio_t           r_prio;
    logic            r_en;
    logic [ID_W-1:0] r_id;
    idx_t            r_base;
    logic [7:0]      r_len;
    logic [7:0]      r_beat;
    logic            r_werr;
    logic            r_bvalid;
    logic [1:0]      r_bresp;
    logic            r_rvalid;
    logic            r_rlast;
    logic [511:0]    r_rdata;
    logic [511:0]    r_mem [DEPTH];

    logic            w_stall_ok;
    logic            w_idle_ok;
    logic            w_aw_hs;
    logic            w_ar_hs;
    logic            w_w_hs;
    logic            w_b_hs;
    logic            w_r_hs;
    logic            w_w_final;
    logic            w_wlast_err;
    logic [7:0]      w_rd_beat;
    idx_t            w_wr_idx;
    idx_t            w_rd_idx;
    logic [511:0]    w_rd_word;
    logic            w_unused;

`ifdef AXI_MEM_RESPONDER_STALL_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall_ok = r_lfsr[0];
`else
    assign w_stall_ok = 1'b1;
`endif

    // NOTE: the address readies look at both valids so they can never be high together.
    assign w_idle_ok   = (r_state == S_IDLE) && r_en && w_stall_ok;
    assign axi.awready = w_idle_ok && axi.awvalid && (!axi.arvalid || r_prio == PRIO_WRITE);
    assign axi.arready = w_idle_ok && axi.arvalid && (!axi.awvalid || r_prio == PRIO_READ);
    assign axi.wready  = (r_state == S_WRITE) && w_stall_ok;

    assign axi.bvalid = r_bvalid;
    assign axi.bresp  = r_bresp;
    assign axi.bid    = r_id;
    assign axi.rvalid = r_rvalid;
    assign axi.rlast  = r_rlast;
    assign axi.rdata  = r_rdata;
    assign axi.rid    = r_id;
    assign axi.rresp  = 2'b00;

    assign w_aw_hs     = axi.awvalid && axi.awready;
    assign w_ar_hs     = axi.arvalid && axi.arready;
    assign w_w_hs      = axi.wvalid && axi.wready;
    assign w_b_hs      = r_bvalid && axi.bready;
    assign w_r_hs      = r_rvalid && axi.rready;
    assign w_w_final   = (r_beat == r_len);
    assign w_wlast_err = (axi.wlast != w_w_final);

    // Read prefetch: look one beat ahead whenever the current beat is consumed.
    assign w_rd_beat = r_beat + {7'd0, w_r_hs};
    assign w_wr_idx  = r_base + idx_t'(r_beat);
    assign w_rd_idx  = r_base + idx_t'(w_rd_beat);
    assign w_rd_word = r_mem[w_rd_idx];

    assign w_unused = ^{axi.wid, axi.awsize, axi.arsize, axi.awaddr, axi.araddr};

    // NOTE: the storage array has no reset; contents survive rstn and start undefined.
    always_ff @(posedge clk) begin
        if (w_w_hs) begin
            for (int j = 0; j < 64; j++) begin
                if (axi.wstrb[j]) begin
                    r_mem[w_wr_idx][8*j +: 8] <= axi.wdata[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_prio   <= PRIO_READ;
            r_en     <= 1'b0;
            r_id     <= '0;
            r_base   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_werr   <= 1'b0;
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_en <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_state <= S_WRITE;
                        r_id    <= axi.awid;
                        r_base  <= axi.awaddr[6 +: DEPTH_LOG2];
                        r_len   <= axi.awlen;
                        r_beat  <= '0;
                        r_werr  <= 1'b0;
                        if (axi.arvalid) r_prio <= PRIO_READ;
                    end else if (w_ar_hs) begin
                        r_state <= S_READ;
                        r_id    <= axi.arid;
                        r_base  <= axi.araddr[6 +: DEPTH_LOG2];
                        r_len   <= axi.arlen;
                        r_beat  <= '0;
                        if (axi.awvalid) r_prio <= PRIO_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_w_hs) begin
                        r_beat <= r_beat + 8'd1;
                        if (w_wlast_err) r_werr <= 1'b1;
                        // The burst ends on the beat count; a misplaced wlast only flags SLVERR.
                        if (w_w_final) begin
                            r_state  <= S_WRESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_wlast_err) ? 2'b10 : 2'b00;
                        end
                    end
                end
                S_WRESP: begin
                    if (w_b_hs) begin
                        r_state  <= S_IDLE;
                        r_bvalid <= 1'b0;
                        r_bresp  <= 2'b00;
                    end
                end
                S_READ: begin
                    if (!r_rvalid || axi.rready) begin
                        if (w_r_hs && r_rlast) begin
                            r_state  <= S_IDLE;
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_rd_word;
                            r_rlast  <= (w_rd_beat == r_len);
                            r_beat   <= w_rd_beat;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: drivers queue expected B/R responses,
// a negedge monitor pops and compares whenever the responder presents them.
`timescale 1ns/1ps
module tb_axi_mem_responder;
    localparam int ID_W = 4;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [511:0]    data;
        logic            last;
    } r_exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_bus_t #(.ID_W(ID_W), .ADDR_W(32)) axi ();

    axi_mem_responder #(.DEPTH_LOG2(12), .ID_W(ID_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .axi  (axi.master)
    );

    b_exp_t       exp_b[$];
    r_exp_t       exp_r[$];
    logic         acc_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           r_seen = 0;
    logic [511:0] wd [8];
    logic [63:0]  ws [8];
    logic         wl [8];
    logic [511:0] rd_exp [8];
    logic [3:0]   rr_pat = 4'b1111;
    logic [1:0]   rr_idx = 2'd0;
    b_exp_t       mon_b;
    r_exp_t       mon_r;

    function automatic logic [511:0] fill(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic set_beat(input int k, input logic [7:0] b, input logic last);
        wd[k] = fill(b);
        ws[k] = '1;
        wl[k] = last;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_awready"}, 512'(axi.awready), 512'(0));
        check({tag, "_wready"},  512'(axi.wready),  512'(0));
        check({tag, "_arready"}, 512'(axi.arready), 512'(0));
        check({tag, "_bvalid"},  512'(axi.bvalid),  512'(0));
        check({tag, "_bresp"},   512'(axi.bresp),   512'(0));
        check({tag, "_bid"},     512'(axi.bid),     512'(0));
        check({tag, "_rvalid"},  512'(axi.rvalid),  512'(0));
        check({tag, "_rresp"},   512'(axi.rresp),   512'(0));
        check({tag, "_rlast"},   512'(axi.rlast),   512'(0));
        check({tag, "_rid"},     512'(axi.rid),     512'(0));
        check({tag, "_rdata"},   axi.rdata,         512'(0));
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input int len, input logic [1:0] resp);
        int n;
        exp_b.push_back('{id: id, resp: resp});
        axi.awid    = id;
        axi.awaddr  = addr;
        axi.awlen   = 8'(len);
        axi.awsize  = 3'd6;
        axi.awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.awready && n < 400);
        check("aw_accept", 512'(axi.awready), 512'(1));
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            axi.wid    = id;
            axi.wdata  = wd[k];
            axi.wstrb  = ws[k];
            axi.wlast  = wl[k];
            axi.wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!axi.wready && n < 400);
            check("w_accept", 512'(axi.wready), 512'(1));
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len);
        int n;
        for (int k = 0; k <= len; k++) begin
            exp_r.push_back('{id: id, data: rd_exp[k], last: (k == len)});
        end
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = 8'(len);
        axi.arsize  = 3'd6;
        axi.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && n < 400);
        check("ar_accept", 512'(axi.arready), 512'(1));
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("drain", 512'(exp_b.size() + exp_r.size()), 512'(0));
        @(posedge clk); #1;
    endtask

    task automatic check_order(input string tag, input logic first);
        check({tag, "_accepts"}, 512'(acc_q.size()), 512'(2));
        if (acc_q.size() >= 2) begin
            check({tag, "_first"},  512'(acc_q[0]), 512'(first));
            check({tag, "_second"}, 512'(acc_q[1]), 512'(!first));
        end
        acc_q.delete();
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Monitor: samples mid-cycle, so a valid&ready seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (axi.awready || axi.arready)
                check("ready_exclusive", 512'(axi.awready & axi.arready), 512'(0));
            if (axi.awvalid && axi.awready) acc_q.push_back(1'b0);
            if (axi.arvalid && axi.arready) acc_q.push_back(1'b1);
            if (axi.bvalid && axi.bready) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 512'(axi.bvalid), 512'(0));
                end else begin
                    mon_b = exp_b.pop_front();
                    check("bid",   512'(axi.bid),   512'(mon_b.id));
                    check("bresp", 512'(axi.bresp), 512'(mon_b.resp));
                end
            end
            if (axi.rvalid) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected", 512'(axi.rvalid), 512'(0));
                end else begin
                    mon_r = exp_r[0];
                    check("rdata", axi.rdata,         mon_r.data);
                    check("rid",   512'(axi.rid),     512'(mon_r.id));
                    check("rlast", 512'(axi.rlast),   512'(mon_r.last));
                    check("rresp", 512'(axi.rresp),   512'(0));
                    if (axi.rready) begin
                        void'(exp_r.pop_front());
                        r_seen++;
                    end
                end
            end
        end
    end

    initial begin
        axi.rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            axi.rready = rr_pat[rr_idx];
            rr_idx++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        axi.awvalid = 1'b0; axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0;
        axi.wvalid = 1'b0; axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.arvalid = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
        axi.bready = 1'b1;

        @(posedge clk); #1;
        check_outputs_zero("por");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Single write then read; readies gated in the first cycle after reset.
        set_beat(0, 8'hA5, 1'b1);
        fork
            do_write(4'h3, 32'h40, 0, 2'b00);
            begin @(negedge clk); check("ready_gated_first_cycle", 512'(axi.awready), 512'(0)); end
        join
        @(negedge clk); check("b_latency", 512'(axi.bvalid), 512'(1));
        wait_drain();
        rd_exp[0] = fill(8'hA5);
        do_read(4'h5, 32'h40, 0);
        @(negedge clk); check("r_latency_t1", 512'(axi.rvalid), 512'(0));
        @(negedge clk); check("r_latency_t2", 512'(axi.rvalid), 512'(1));
        wait_drain();

        // Strobed burst over a pre-filled word 65, read back with rready toggling.
        set_beat(0, 8'hEE, 1'b1);
        do_write(4'h1, 32'h1040, 0, 2'b00);
        wait_drain();
        set_beat(0, 8'h11, 1'b0);
        set_beat(1, 8'h22, 1'b0);
        ws[1] = 64'h0F;
        set_beat(2, 8'h33, 1'b0);
        set_beat(3, 8'h44, 1'b1);
        do_write(4'h1, 32'h1000, 3, 2'b00);
        wait_drain();
        rd_exp[0] = fill(8'h11);
        rd_exp[1] = {{60{8'hEE}}, {4{8'h22}}};
        rd_exp[2] = fill(8'h33);
        rd_exp[3] = fill(8'h44);
        rr_pat = 4'b0101;
        do_read(4'h2, 32'h1000, 3);
        wait_drain();
        rr_pat = 4'b1111;

        // Wrap-around at the top word and address aliasing.
        set_beat(0, 8'h5A, 1'b0);
        set_beat(1, 8'hC3, 1'b1);
        do_write(4'h6, 32'h3FFC0, 1, 2'b00);
        wait_drain();
        rd_exp[0] = fill(8'hC3);
        do_read(4'h7, 32'h0, 0);
        wait_drain();
        do_read(4'h8, 32'h40000, 0);
        wait_drain();
        rd_exp[0] = fill(8'h5A);
        rd_exp[1] = fill(8'hC3);
        do_read(4'h9, 32'h3FFC0, 1);
        wait_drain();

        // Misplaced wlast: early on a 3-beat burst, missing on a single beat.
        set_beat(0, 8'h61, 1'b0);
        set_beat(1, 8'h62, 1'b1);
        set_beat(2, 8'h63, 1'b0);
        do_write(4'hA, 32'h3200, 2, 2'b10);
        wait_drain();
        rd_exp[0] = fill(8'h61);
        rd_exp[1] = fill(8'h62);
        rd_exp[2] = fill(8'h63);
        do_read(4'hB, 32'h3200, 2);
        wait_drain();
        set_beat(0, 8'h64, 1'b0);
        do_write(4'hC, 32'h3300, 0, 2'b10);
        wait_drain();

        // Contention: priority starts at READ after reset and alternates.
        apply_reset();
        acc_q.delete();
        set_beat(0, 8'h77, 1'b1);
        rd_exp[0] = fill(8'h11);
        fork
            do_write(4'h1, 32'h280, 0, 2'b00);
            do_read(4'h2, 32'h1000, 0);
        join
        wait_drain();
        check_order("contention1", 1'b1);
        set_beat(0, 8'h78, 1'b1);
        rd_exp[0] = fill(8'h77);
        fork
            do_write(4'h3, 32'h2C0, 0, 2'b00);
            do_read(4'h4, 32'h280, 0);
        join
        wait_drain();
        check_order("contention2", 1'b0);
        set_beat(0, 8'h79, 1'b1);
        rd_exp[0] = fill(8'h78);
        fork
            do_write(4'h5, 32'h300, 0, 2'b00);
            do_read(4'h6, 32'h2C0, 0);
        join
        wait_drain();
        check_order("contention3", 1'b1);

        // Reset during beat 2 of an 8-beat read.
        for (int k = 0; k < 8; k++) set_beat(k, 8'(8'h80 + k), k == 7);
        do_write(4'h3, 32'h4B00, 7, 2'b00);
        wait_drain();
        for (int k = 0; k < 8; k++) rd_exp[k] = fill(8'(8'h80 + k));
        r_seen = 0;
        do_read(4'h4, 32'h4B00, 7);
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!(axi.rvalid && r_seen == 2) && n < 100);
        check("reached_beat2", 512'(r_seen), 512'(2));
        rstn = 1'b0;
        #1;
        check_outputs_zero("mid_read_reset");
        exp_r.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("post_reset_rvalid", 512'(axi.rvalid), 512'(0));
        check("post_reset_wready", 512'(axi.wready), 512'(0));
        @(negedge clk);
        check("post_reset_no_stale_r", 512'(axi.rvalid), 512'(0));
        check("post_reset_no_b", 512'(axi.bvalid), 512'(0));
        @(posedge clk); #1;
        rd_exp[0] = fill(8'h82);
        rd_exp[1] = fill(8'h83);
        do_read(4'h7, 32'h4B80, 1);
        wait_drain();

        check("final_queues_empty", 512'(exp_b.size() + exp_r.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
